// File: rtl/uart_rx_param.sv
// Purpose: oversampling UART receiver with configurable data width, parity mode and stop-bit count.
// Latency: word presented one cycle after the final stop-bit sample, which is taken mid stop bit.
// Backpressure: one-word holding register; a frame completing while the held word is unaccepted is dropped and overrun pulses.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam int              HALF      = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0]   HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0]   FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic                 sync1_q, sync2_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_err_q, stop_err_d;
  logic                 wait_high_q, wait_high_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic line;
  logic frame_done;
  logic frame_ferr;
  logic frame_perr;
  logic par_xor;

  assign line = sync2_q;

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_rx;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: bit timing, sampling, and the holding register update at frame end.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    stop_err_d  = stop_err_q;
    wait_high_d = wait_high_q;
    frame_done  = 1'b0;
    frame_ferr  = stop_err_q | ~line;
    par_xor     = (^shift_q) ^ par_bit_q;
    frame_perr  = (PARITY == 1) ? par_xor : (PARITY == 2) ? ~par_xor : 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // After a framing error the line must return high before a new start counts.
        if (wait_high_q) begin
          if (line) wait_high_d = 1'b0;
        end else if (!line) begin
          state_d    = S_START;
          stop_err_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) state_d = line ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                    bit_d   = bit_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          par_bit_d = line;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          stop_err_d = frame_ferr;
          if (bit_q == STOP_LAST) begin
            state_d     = S_IDLE;
            frame_done  = 1'b1;
            wait_high_d = frame_ferr;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      bit_d = '0;
    end

    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    valid_d = valid_q & ~rx_ready;
    if (frame_done) begin
      // A word accepted in the completion cycle frees the register for the new frame.
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = frame_perr;
        ferr_d  = frame_ferr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      wait_high_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      stop_err_q  <= stop_err_d;
      wait_high_q <= wait_high_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);
endmodule
